// File: rtl/booth_pp_engine.sv
// Iterative Booth multiplier: radix-2 or radix-4 recoding chosen per operation,
// signed or unsigned operands, valid/ready on both sides.
module booth_pp_engine #(
    parameter  int WIDTH = 16,
    localparam int N     = WIDTH + 2,
    localparam int PP_W  = 2 * N + 2,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic                 radix4,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic [PP_W-1:0]      pp_out,
    output logic [CNT_W-1:0]     iter_cnt
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q;
    logic [N-1:0]         m_q;
    logic                 radix4_q;
    logic [PP_W-1:0]      pp_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   result_q;

    logic [N-1:0]         a_ext;
    logic [N-1:0]         b_ext;
    logic [N:0]           m_ext;
    logic [N:0]           m2_ext;
    logic [N:0]           addend;
    logic [N:0]           a_sum;
    logic signed [PP_W-1:0] sum_vec;
    logic [PP_W-1:0]      pp_step_d;

    always_comb begin
        a_ext = signed_mode ? {{(N-WIDTH){a[WIDTH-1]}}, a} : {{(N-WIDTH){1'b0}}, a};
        b_ext = signed_mode ? {{(N-WIDTH){b[WIDTH-1]}}, b} : {{(N-WIDTH){1'b0}}, b};
    end

    // Layout of pp_q is {A[N:0], Q[N-1:0], q_1}; the recoding window sits in the low bits.
    always_comb begin
        m_ext  = {m_q[N-1], m_q};
        m2_ext = {m_q, 1'b0};
        addend = '0;
        if (radix4_q) begin
            case (pp_q[2:0])
                3'b001, 3'b010: addend = m_ext;
                3'b011:         addend = m2_ext;
                3'b100:         addend = -m2_ext;
                3'b101, 3'b110: addend = -m_ext;
                default:        addend = '0;
            endcase
        end else begin
            case (pp_q[1:0])
                2'b01:   addend = m_ext;
                2'b10:   addend = -m_ext;
                default: addend = '0;
            endcase
        end
        a_sum     = pp_q[PP_W-1:N+1] + addend;
        sum_vec   = {a_sum, pp_q[N:0]};
        pp_step_d = radix4_q ? (sum_vec >>> 2) : (sum_vec >>> 1);
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: m_q and radix4_q are pure datapath, always loaded at accept before use, so they skip reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pp_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            pp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        m_q      <= a_ext;
                        radix4_q <= radix4;
                        pp_q     <= {{(N+1){1'b0}}, b_ext, 1'b0};
                        cnt_q    <= radix4 ? CNT_W'(N / 2) : CNT_W'(N);
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    pp_q  <= pp_step_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        result_q <= pp_step_d[2*WIDTH:1];
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == BUSY);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign pp_out    = pp_q;
    assign iter_cnt  = cnt_q;

endmodule

// File: tb/tb_booth_pp_engine.sv
// Scoreboarded bench for booth_pp_engine (WIDTH=16): directed corners, backpressure,
// flush, mid-operation reset and a randomised sweep over all mode combinations.
module tb_booth_pp_engine;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH + 2;
    localparam int PP_W  = 2 * N + 2;
    localparam int CNT_W = $clog2(N + 1);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 radix4;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;
    logic [PP_W-1:0]      pp_out;
    logic [CNT_W-1:0]     iter_cnt;

    booth_pp_engine #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .radix4(radix4),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .busy(busy), .pp_out(pp_out), .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2*WIDTH-1:0] sb[$];
    logic [2*WIDTH-1:0] last_result = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*WIDTH-1:0] ref_prod(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y, input bit s);
        longint px, py;
        px = s ? longint'($signed(x)) : longint'(x);
        py = s ? longint'($signed(y)) : longint'(y);
        return (2*WIDTH)'(px * py);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        last_result = '0;
    endtask

    task automatic accept_op(input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                             input bit s, input bit r4, output bit ok);
        int g = 0;
        a = a_v; b = b_v; signed_mode = s; radix4 = r4; in_valid = 1'b1;
        while (!in_ready && g < 50) begin
            tick();
            g++;
        end
        if (!in_ready) begin
            check("accept_wait", 64'(in_ready), 64'(1));
            in_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        signed_mode = 1'($urandom);
        radix4 = 1'($urandom);
        sb.push_back(ref_prod(a_v, b_v, s));
        check("busy_after_accept", 64'(busy), 64'(1));
        check("iter_load", 64'(iter_cnt), r4 ? 64'(N / 2) : 64'(N));
        ok = 1'b1;
    endtask

    task automatic finish_op(input int stall, input int exp_lat, input bit poke);
        int lat = 0;
        logic [2*WIDTH-1:0] exp;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        if (!out_valid || sb.size() == 0) begin
            check("output_present", 64'(out_valid && sb.size() != 0), 64'(1));
            do_reset();
            return;
        end
        exp = sb[0];
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                in_valid = 1'b1;
                a = 16'h1234; b = 16'h0002;
            end
            tick();
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_result", 64'(result), 64'(exp));
            check("hold_in_ready", 64'(in_ready), 64'(0));
            check("hold_not_busy", 64'(busy), 64'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        exp = sb.pop_front();
        check("result", 64'(result), 64'(exp));
        tick();
        out_ready = 1'b0;
        last_result = exp;
        check("in_ready_after_hs", 64'(in_ready), 64'(1));
        check("out_valid_after_hs", 64'(out_valid), 64'(0));
        check("result_retained", 64'(result), 64'(exp));
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                          input bit s, input bit r4, input int stall);
        bit ok;
        accept_op(a_v, b_v, s, r4, ok);
        if (ok) finish_op(stall, r4 ? N / 2 : N, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_result"}, 64'(result), 64'(0));
        check({tag, "_pp_out"}, 64'(pp_out), 64'(0));
        check({tag, "_iter_cnt"}, 64'(iter_cnt), 64'(0));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        bit saw_valid;
        logic [WIDTH-1:0] av, bv;
        logic [WIDTH-1:0] corners [4];
        corners[0] = 16'h0000; corners[1] = 16'h0001;
        corners[2] = 16'h8000; corners[3] = 16'hFFFF;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; signed_mode = 1'b0; radix4 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_outputs("reset");

        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 0);
        check("u_r2_ffff", 64'(last_result), 64'h0000_0000_FFFE_0001);
        run_op(16'h8000, 16'h8000, 1'b1, 1'b1, 0);
        check("s_r4_8000", 64'(last_result), 64'h0000_0000_4000_0000);
        run_op(16'h8000, 16'h7FFF, 1'b1, 1'b1, 0);
        check("s_r4_7fff", 64'(last_result), 64'h0000_0000_C000_8000);

        accept_op(16'd3, 16'd5, 1'b0, 1'b0, ok);
        if (ok) finish_op(20, N, 1'b1);
        check("backpressure_result", 64'(last_result), 64'h0000_0000_0000_000F);

        accept_op(16'h5A5A, 16'h1234, 1'b0, 1'b1, ok);
        if (ok) begin
            repeat (3) tick();
            flush = 1'b1;
            tick();
            flush = 1'b0;
            void'(sb.pop_back());
            check("flush_in_ready", 64'(in_ready), 64'(1));
            check("flush_busy", 64'(busy), 64'(0));
            check("flush_pp_out", 64'(pp_out), 64'(0));
            check("flush_iter_cnt", 64'(iter_cnt), 64'(0));
            check("flush_result_kept", 64'(result), 64'(last_result));
            saw_valid = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (out_valid) saw_valid = 1'b1;
                tick();
            end
            check("flush_no_valid", 64'(saw_valid), 64'(0));
        end
        run_op(16'd7, 16'hFFFE, 1'b1, 1'b0, 0);
        check("after_flush_result", 64'(last_result), 64'h0000_0000_FFFF_FFF2);

        for (int i = 0; i < 400; i++) begin
            av = ($urandom_range(0, 5) == 0) ? corners[$urandom_range(0, 3)] : WIDTH'($urandom);
            bv = ($urandom_range(0, 5) == 0) ? corners[$urandom_range(0, 3)] : WIDTH'($urandom);
            run_op(av, bv, 1'($urandom), 1'($urandom), $urandom_range(0, 2));
        end

        accept_op(16'h1357, 16'h2468, 1'b1, 1'b0, ok);
        if (ok) begin
            repeat (4) tick();
            check("pre_reset_busy", 64'(busy), 64'(1));
            reset = 1'b1;
            tick();
            reset = 1'b0;
            void'(sb.pop_back());
            check_reset_outputs("midop_reset");
        end
        run_op(16'hFFFF, 16'h0002, 1'b1, 1'b1, 1);
        check("after_reset_result", 64'(last_result), 64'h0000_0000_FFFF_FFFE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
